// File: rtl/bcd_stopwatch_pkg.sv
// ============================================================================
// Module   : bcd_stopwatch_pkg
// Purpose  : Shared state encoding and width constants for the BCD stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_stopwatch_pkg;
  localparam int C_DIGIT_W    = 4;
  localparam int C_PRESCALE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/bcd_stopwatch_digit.sv
// ============================================================================
// Module   : bcd_digit
// Purpose  : One BCD decade with synchronous clear and ripple carry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 i_clear,
  input  logic                 i_inc_en,
  input  logic                 i_carry_in,
  output logic                 o_carry_out,
  output logic [C_DIGIT_W-1:0] o_value
);

  logic [C_DIGIT_W-1:0] r_value;
  logic                 w_at_nine;

  assign w_at_nine   = (r_value == C_DIGIT_W'(9));
  assign o_carry_out = i_carry_in & w_at_nine;
  assign o_value     = r_value;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_value <= '0;
    end else if (i_clear) begin
      r_value <= '0;
    end else if (i_inc_en && i_carry_in) begin
      r_value <= w_at_nine ? '0 : r_value + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_stopwatch.sv
// ============================================================================
// Module   : bcd_stopwatch
// Purpose  : Start/stop/clear BCD stopwatch counting synchronized tick rises.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_COUNT = 1
) (
  input  logic                          clock_in,
  input  logic                          reset_n,
  input  logic                          tick_in,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          clear,
  output logic [C_DIGIT_W*DIGITS-1:0]   count_bcd,
  output logic                          running,
  output logic                          wrap_pulse
);

  localparam logic [C_PRESCALE_W-1:0] C_TERMINAL = C_PRESCALE_W'(TICKS_PER_COUNT - 1);

  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_prev;
  logic [1:0]              r_fill;
  logic                    r_armed;
  logic                    r_tick_rise;
  state_t                  r_state;
  logic [C_PRESCALE_W-1:0] r_prescale;
  logic                    r_running;
  logic                    r_wrap;

  logic                    w_advance;
  logic                    w_terminal;
  logic                    w_inc;
  logic [DIGITS-1:0]       w_carry;

  // A level already high at reset release must fall before a rise is honoured,
  // so edges are only armed once a genuine low sample has reached r_sync2.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b0;
      r_fill      <= 2'b00;
      r_armed     <= 1'b0;
      r_tick_rise <= 1'b0;
    end else begin
      r_sync1     <= tick_in;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_fill      <= {r_fill[0], 1'b1};
      r_armed     <= r_armed | (r_fill[1] & ~r_sync2);
      r_tick_rise <= r_sync2 & ~r_prev & r_armed;
    end
  end

  assign w_advance  = (r_state == ST_RUN) & r_tick_rise & ~stop & ~clear;
  assign w_terminal = (r_prescale == C_TERMINAL);
  assign w_inc      = w_advance & w_terminal;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_prescale <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= w_inc & w_carry[DIGITS-1];
      if (clear) begin
        r_state    <= ST_IDLE;
        r_running  <= 1'b0;
        r_prescale <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_PAUSE: begin
            if (start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stop) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else if (w_advance) begin
              r_prescale <= w_terminal ? '0 : r_prescale + 1'b1;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic w_cin;
    if (gi == 0) begin : g_lsd
      assign w_cin = 1'b1;
    end else begin : g_upper
      assign w_cin = w_carry[gi-1];
    end

    bcd_digit u_digit (
      .clock_in    (clock_in),
      .reset_n     (reset_n),
      .i_clear     (clear),
      .i_inc_en    (w_inc),
      .i_carry_in  (w_cin),
      .o_carry_out (w_carry[gi]),
      .o_value     (count_bcd[gi*C_DIGIT_W +: C_DIGIT_W])
    );
  end

  assign running    = r_running;
  assign wrap_pulse = r_wrap;

endmodule

`default_nettype wire
